// File: rtl/dwpe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dwpe_seq_ctrl
//   Tap sequencer for the depthwise PE array. For every channel of a tile it
//   steps the KS x KS kernel taps, issuing weight-buffer reads, pixel-window
//   selects, PE enable and accumulator clear. It also flags the cycle in which
//   each channel's array result becomes final.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        one-cycle tile request, sampled only in IDLE
//   num_ch       channels in tile, sampled with start
//   pix_ready    pixel window buffer can supply data this cycle (0 = stall)
//   busy         high while the tile is being issued / drained
//   done         one-cycle pulse once every channel has been captured
//   wt_rd_en     weight buffer read strobe (pix_ready-gated)
//   wt_rd_addr   ch*KS*KS + ky*KS + kx of the tap being read
//   dwpe_ena     array enable, one cycle after the matching wt_rd_en
//   pix_sel_ky   kernel row of the tap, aligned with dwpe_ena
//   pix_sel_kx   kernel column of the tap, aligned with dwpe_ena
//   acc_clr      accumulator clear, aligned with dwpe_ena of tap (0,0)
//   res_capture  array result for res_ch is final this cycle
//   res_ch       channel index belonging to res_capture
// -----------------------------------------------------------------------------
module dwpe_seq_ctrl #(
    parameter int KS  = 3,
    parameter int CHW = 8,
    parameter int AW  = 12,
    parameter int LAT = 2,
    localparam int KW = (KS > 1) ? $clog2(KS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [CHW-1:0] num_ch,
    input  logic           pix_ready,
    output logic           busy,
    output logic           done,
    output logic           wt_rd_en,
    output logic [AW-1:0]  wt_rd_addr,
    output logic           dwpe_ena,
    output logic [KW-1:0]  pix_sel_ky,
    output logic [KW-1:0]  pix_sel_kx,
    output logic           acc_clr,
    output logic           res_capture,
    output logic [CHW-1:0] res_ch
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic           busy_q;
    logic           done_q;
    logic [CHW-1:0] num_ch_q;
    logic [CHW-1:0] ch_q;
    logic [KW-1:0]  ky_q;
    logic [KW-1:0]  kx_q;
    logic [AW-1:0]  addr_q;

    // Stage-1 (array-side) registers
    logic           s1_vld_q;
    logic [KW-1:0]  s1_ky_q;
    logic [KW-1:0]  s1_kx_q;
    logic           s1_clr_q;
    logic           s1_last_q;
    logic [CHW-1:0] s1_ch_q;

    // Latency pipeline: only channel-final taps are carried
    logic [LAT-1:0] lat_last_q;
    logic [CHW-1:0] lat_ch_q [LAT];

    logic issue;
    logic kx_wrap;
    logic ky_wrap;
    logic ch_wrap;
    logic pending;

    // The only input-to-output path: a stalled pixel buffer suppresses the read.
    assign issue   = (state_q == S_RUN) && pix_ready;
    assign kx_wrap = (kx_q == KW'(KS - 1));
    assign ky_wrap = (ky_q == KW'(KS - 1));
    assign ch_wrap = (ch_q == (num_ch_q - CHW'(1)));

    // The final tap of a tile is always a channel-final tap and the youngest
    // entry in flight, so the tile is drained once it has reached the last
    // latency stage. Older, non-final taps need no tracking.
    always_comb begin
        pending = s1_vld_q;
        for (int k = 0; k < LAT - 1; k++) begin
            pending = pending | lat_last_q[k];
        end
    end

    // Control FSM with its registered status outputs and tap counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            num_ch_q <= '0;
            ch_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            addr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ch_q   <= '0;
                        ky_q   <= '0;
                        kx_q   <= '0;
                        addr_q <= '0;
                        if (num_ch != '0) begin
                            num_ch_q <= num_ch;
                            busy_q   <= 1'b1;
                            state_q  <= S_RUN;
                        end else begin
                            // Empty tile: report completion without issuing taps
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        // Taps are issued in address order, so the address
                        // simply counts up alongside the (ch,ky,kx) counters.
                        addr_q <= addr_q + AW'(1);
                        if (kx_wrap) begin
                            kx_q <= '0;
                            if (ky_wrap) begin
                                ky_q <= '0;
                                if (ch_wrap) begin
                                    ch_q    <= '0;
                                    state_q <= S_DRAIN;
                                end else begin
                                    ch_q <= ch_q + CHW'(1);
                                end
                            end else begin
                                ky_q <= ky_q + KW'(1);
                            end
                        end else begin
                            kx_q <= kx_q + KW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pending) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    addr_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 1: delay the issued tap by one cycle to line up with weight data.
    // Selects are forced to zero on bubbles so idle outputs stay quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_ky_q   <= '0;
            s1_kx_q   <= '0;
            s1_clr_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_ch_q   <= '0;
        end else begin
            s1_vld_q  <= issue;
            s1_ky_q   <= issue ? ky_q : '0;
            s1_kx_q   <= issue ? kx_q : '0;
            s1_clr_q  <= issue && (ky_q == '0) && (kx_q == '0);
            s1_last_q <= issue && ky_wrap && kx_wrap;
            s1_ch_q   <= issue ? ch_q : '0;
        end
    end

    // Latency pipeline from dwpe_ena to final array result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_last_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                lat_ch_q[k] <= '0;
            end
        end else begin
            lat_last_q[0] <= s1_last_q;
            lat_ch_q[0]   <= s1_last_q ? s1_ch_q : '0;
            for (int k = 1; k < LAT; k++) begin
                lat_last_q[k] <= lat_last_q[k-1];
                lat_ch_q[k]   <= lat_ch_q[k-1];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign wt_rd_en    = issue;
    assign wt_rd_addr  = addr_q;
    assign dwpe_ena    = s1_vld_q;
    assign pix_sel_ky  = s1_ky_q;
    assign pix_sel_kx  = s1_kx_q;
    assign acc_clr     = s1_clr_q;
    assign res_capture = lat_last_q[LAT-1];
    assign res_ch      = lat_ch_q[LAT-1];

endmodule

// File: tb/tb_dwpe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dwpe_seq_ctrl
//   Directed bench for dwpe_seq_ctrl with KS=3, CHW=8, AW=12, LAT=2.
//   Cycle 0 is the cycle in which start is driven; inputs change 1 time unit
//   after the rising edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dwpe_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  num_ch;
    logic        pix_ready;
    logic        busy;
    logic        done;
    logic        wt_rd_en;
    logic [11:0] wt_rd_addr;
    logic        dwpe_ena;
    logic [1:0]  pix_sel_ky;
    logic [1:0]  pix_sel_kx;
    logic        acc_clr;
    logic        res_capture;
    logic [7:0]  res_ch;

    int errors = 0;
    int checks = 0;

    dwpe_seq_ctrl #(
        .KS (3),
        .CHW(8),
        .AW (12),
        .LAT(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_ch     (num_ch),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .done       (done),
        .wt_rd_en   (wt_rd_en),
        .wt_rd_addr (wt_rd_addr),
        .dwpe_ena   (dwpe_ena),
        .pix_sel_ky (pix_sel_ky),
        .pix_sel_kx (pix_sel_kx),
        .acc_clr    (acc_clr),
        .res_capture(res_capture),
        .res_ch     (res_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed=%0d expected=%0d", tag, c, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag, input int c);
        chk({tag, ".busy"},        c, 32'(busy),        0);
        chk({tag, ".done"},        c, 32'(done),        0);
        chk({tag, ".wt_rd_en"},    c, 32'(wt_rd_en),    0);
        chk({tag, ".wt_rd_addr"},  c, 32'(wt_rd_addr),  0);
        chk({tag, ".dwpe_ena"},    c, 32'(dwpe_ena),    0);
        chk({tag, ".pix_sel_ky"},  c, 32'(pix_sel_ky),  0);
        chk({tag, ".pix_sel_kx"},  c, 32'(pix_sel_kx),  0);
        chk({tag, ".acc_clr"},     c, 32'(acc_clr),     0);
        chk({tag, ".res_capture"}, c, 32'(res_capture), 0);
        chk({tag, ".res_ch"},      c, 32'(res_ch),      0);
    endtask

    // One tile: start at cycle 0, pix_ready low over [st_lo,st_hi], an extra
    // (to-be-ignored) start at restart_c, and an async reset at abort_c.
    // Negative values disable the corresponding event.
    task automatic run_case(input string name, input int nch, input int st_lo, input int st_hi,
                            input int restart_c, input int abort_c, input int ncyc);
        int iss[64];
        int taps;
        int issued;
        int last_iss;
        int done_c;
        int reads;
        int d;
        int r;
        bit stall;
        taps     = nch * 9;
        issued   = 0;
        last_iss = 0;
        reads    = 0;
        for (int c = 0; c < 64; c++) begin
            stall  = (c >= st_lo) && (c <= st_hi);
            iss[c] = -1;
            if (c >= 1 && issued < taps && !stall) begin
                iss[c]   = issued;
                issued++;
                last_iss = c;
            end
        end
        done_c = (taps == 0) ? 1 : last_iss + 4;

        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0) || (c == restart_c);
            num_ch    = 8'(nch);
            pix_ready = !((c >= st_lo) && (c <= st_hi));
            if (abort_c >= 0 && c >= abort_c) begin
                start = 1'b0;
                rst   = (c == abort_c);
            end
            @(negedge clk);
            if (abort_c >= 0 && c >= abort_c) begin
                chk_all_zero({name, ".aborted"}, c);
            end else begin
                chk({name, ".wt_rd_en"}, c, 32'(wt_rd_en), 32'(iss[c] >= 0));
                if (iss[c] >= 0) begin
                    chk({name, ".wt_rd_addr"}, c, 32'(wt_rd_addr), iss[c]);
                end
                if (wt_rd_en === 1'b1) reads++;
                d = (c >= 1) ? iss[c-1] : -1;
                chk({name, ".dwpe_ena"}, c, 32'(dwpe_ena), 32'(d >= 0));
                chk({name, ".acc_clr"},  c, 32'(acc_clr),  32'(d >= 0 && d % 9 == 0));
                if (d >= 0) begin
                    chk({name, ".pix_sel_ky"}, c, 32'(pix_sel_ky), (d % 9) / 3);
                    chk({name, ".pix_sel_kx"}, c, 32'(pix_sel_kx), d % 3);
                end
                r = (c >= 3) ? iss[c-3] : -1;
                chk({name, ".res_capture"}, c, 32'(res_capture), 32'(r >= 0 && r % 9 == 8));
                if (r >= 0 && r % 9 == 8) begin
                    chk({name, ".res_ch"}, c, 32'(res_ch), r / 9);
                end
                if (res_capture === 1'b1) begin
                    $display("[%0t] %s: capture ch=%0d at cycle %0d", $time, name, res_ch, c);
                end
                chk({name, ".busy"}, c, 32'(busy), 32'(taps > 0 && c >= 1 && c < done_c));
                chk({name, ".done"}, c, 32'(done), 32'(c == done_c));
                if (done === 1'b1) begin
                    $display("[%0t] %s: done at cycle %0d", $time, name, c);
                end
            end
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        rst       = 1'b0;
        pix_ready = 1'b1;
        if (abort_c < 0) begin
            chk({name, ".read_count"}, ncyc, 32'(reads), taps);
        end
        $display("[%0t] %s: tile of %0d channels finished, %0d reads", $time, name, nch, reads);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_ch    = 8'd0;
        pix_ready = 1'b1;

        // Reset held for three cycles, then idle with start low
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_all_zero("reset", c);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_all_zero("idle", c);
        end

        run_case("basic",       2, -1, -1, -1, -1, 26);
        run_case("stall",       2,  4,  6, -1, -1, 28);
        run_case("zero_ch",     0, -1, -1, -1, -1,  5);
        run_case("restart",     2, -1, -1,  5, -1, 26);
        run_case("drain_stall", 1, 10, 12, -1, -1, 16);
        run_case("stall_ch",    3,  9, 10, -1, -1, 36);
        run_case("abort",       2, -1, -1, -1,  9, 30);
        run_case("after_rst",   2, -1, -1, -1, -1, 26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
